key_sched_seq: RTL and testbench

//  Sequential, parametrised successor to the single-round key generator.

---
 rtl/key_sched_seq.sv | 128 ++++++++++++
 tb/tb_key_sched_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/key_sched_seq.sv
// rtl/key_sched_seq.sv - sequential round-key scheduler over a valid/ready stream
// Emits the loaded key as round 0, then one derived key per accepted transfer.
module s_box (
  input  logic [3:0] nib_i,
  output logic [3:0] sub_o
);
  always_comb begin
    case (nib_i)
      4'h0: sub_o = 4'h9;
      4'h1: sub_o = 4'h4;
      4'h2: sub_o = 4'hA;
      4'h3: sub_o = 4'hB;
      4'h4: sub_o = 4'hD;
      4'h5: sub_o = 4'h1;
      4'h6: sub_o = 4'h8;
      4'h7: sub_o = 4'h5;
      4'h8: sub_o = 4'h6;
      4'h9: sub_o = 4'h2;
      4'hA: sub_o = 4'h0;
      4'hB: sub_o = 4'h3;
      4'hC: sub_o = 4'hC;
      4'hD: sub_o = 4'hE;
      4'hE: sub_o = 4'hF;
      default: sub_o = 4'h7;
    endcase
  end
endmodule

module key_sched_seq #(
  parameter int NWORDS  = 2,
  parameter int NROUNDS = 2,
  parameter int IDX_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8*NWORDS-1:0]   key_in,
  output logic                  busy,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [8*NWORDS-1:0]   rk_data,
  output logic [IDX_W-1:0]      rk_index,
  output logic                  done
);
  localparam int KW = 8 * NWORDS;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     rk_data_q, rk_data_d;
  logic [IDX_W-1:0]  rk_index_q, rk_index_d;
  logic [3:0]        rcon_q, rcon_d;
  logic              done_q, done_d;

  logic [7:0]        last_w;
  logic [7:0]        g_val;
  logic [3:0]        sub_hi, sub_lo;
  logic [KW-1:0]     next_key;
  logic [7:0]        acc;

  // RotNib then SubNib: the low nibble of the input lands in the high nibble.
  assign last_w = rk_data_q[7:0];
  s_box u_sbox_hi (.nib_i(last_w[3:0]), .sub_o(sub_hi));
  s_box u_sbox_lo (.nib_i(last_w[7:4]), .sub_o(sub_lo));
  assign g_val = {sub_hi, sub_lo} ^ {rcon_q, 4'h0};

  always_comb begin
    next_key = '0;
    acc = rk_data_q[KW-1 -: 8] ^ g_val;
    next_key[KW-1 -: 8] = acc;
    for (int i = 1; i < NWORDS; i++) begin
      acc = acc ^ rk_data_q[8*(NWORDS-1-i) +: 8];
      next_key[8*(NWORDS-1-i) +: 8] = acc;
    end
  end

  always_comb begin
    state_d    = state_q;
    rk_data_d  = rk_data_q;
    rk_index_d = rk_index_q;
    rcon_d     = rcon_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = EMIT;
          rk_data_d  = key_in;
          rk_index_d = '0;
          rcon_d     = 4'h8;
        end
      end
      default: begin
        if (rk_ready) begin
          if (rk_index_q == IDX_W'(NROUNDS)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rk_data_d  = next_key;
            rk_index_d = rk_index_q + IDX_W'(1);
            rcon_d     = {rcon_q[2:0], 1'b0} ^ (rcon_q[3] ? 4'h3 : 4'h0);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rk_data_q  <= '0;
      rk_index_q <= '0;
      rcon_q     <= 4'h8;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_data_q  <= rk_data_d;
      rk_index_q <= rk_index_d;
      rcon_q     <= rcon_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rk_valid = (state_q == EMIT);
  assign rk_data  = rk_data_q;
  assign rk_index = rk_index_q;
  assign done     = done_q;
endmodule

// File: tb/tb_key_sched_seq.sv
// tb/tb_key_sched_seq.sv - directed bench for key_sched_seq
// Three instances: default, 14 rounds, and a 4-word key.
module tb_key_sched_seq;
  logic clk, rst;

  logic        start_a, valid_a, ready_a, busy_a, done_a;
  logic [15:0] key_a, data_a;
  logic [3:0]  idx_a;
  logic        start_b, valid_b, ready_b, busy_b, done_b;
  logic [15:0] key_b, data_b;
  logic [3:0]  idx_b;
  logic        start_c, valid_c, ready_c, busy_c, done_c;
  logic [31:0] key_c, data_c;
  logic [3:0]  idx_c;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] sb [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                          4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
  logic [3:0] rc_tab [14] = '{4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5, 4'hA,
                              4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1, 4'h2};

  key_sched_seq dut_a (
    .clk(clk), .reset(rst), .start(start_a), .key_in(key_a), .busy(busy_a),
    .rk_valid(valid_a), .rk_ready(ready_a), .rk_data(data_a), .rk_index(idx_a), .done(done_a));

  key_sched_seq #(.NWORDS(2), .NROUNDS(14), .IDX_W(4)) dut_b (
    .clk(clk), .reset(rst), .start(start_b), .key_in(key_b), .busy(busy_b),
    .rk_valid(valid_b), .rk_ready(ready_b), .rk_data(data_b), .rk_index(idx_b), .done(done_b));

  key_sched_seq #(.NWORDS(4), .NROUNDS(5), .IDX_W(4)) dut_c (
    .clk(clk), .reset(rst), .start(start_c), .key_in(key_c), .busy(busy_c),
    .rk_valid(valid_c), .rk_ready(ready_c), .rk_data(data_c), .rk_index(idx_c), .done(done_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] k, input int nw, input logic [3:0] rc);
    logic [7:0] w [8];
    logic [7:0] n [8];
    logic [7:0] t, g;
    logic [63:0] r;
    for (int i = 0; i < nw; i++) w[i] = k[8*(nw-1-i) +: 8];
    t = w[nw-1];
    g = {sb[t[3:0]], sb[t[7:4]]} ^ {rc, 4'h0};
    n[0] = w[0] ^ g;
    for (int i = 1; i < nw; i++) n[i] = n[i-1] ^ w[i];
    r = '0;
    for (int i = 0; i < nw; i++) r[8*(nw-1-i) +: 8] = n[i];
    return r;
  endfunction

  task automatic chk_a(input string tag, input logic v, input logic [15:0] d,
                       input logic [3:0] ix, input logic b, input logic dn);
    chk({tag, "_valid"}, valid_a, v);
    chk({tag, "_data"},  data_a,  d);
    chk({tag, "_idx"},   idx_a,   ix);
    chk({tag, "_busy"},  busy_a,  b);
    chk({tag, "_done"},  done_a,  dn);
  endtask

  initial begin
    logic [63:0] exp_k;
    int ntx, cyc;
    rst = 1'b1;
    start_a = 0; key_a = '0; ready_a = 1;
    start_b = 0; key_b = '0; ready_b = 1;
    start_c = 0; key_c = '0; ready_c = 0;
    step(); step();
    rst = 1'b0;
    chk_a("rst", 0, 16'h0000, 0, 0, 0);
    chk("rst_b_valid", valid_b, 0);
    chk("rst_c_busy", busy_c, 0);

    // T1: back-to-back transfers
    start_a = 1; key_a = 16'h4AF5; step(); start_a = 0;
    chk_a("t1_k0", 1, 16'h4AF5, 0, 1, 0);
    step(); chk_a("t1_k1", 1, 16'hDD28, 1, 1, 0);
    step(); chk_a("t1_k2", 1, 16'h87AF, 2, 1, 0);
    step(); chk_a("t1_done", 0, 16'h87AF, 2, 0, 1);
    step(); chk_a("t1_idle", 0, 16'h87AF, 2, 0, 0);

    // T2: stall at index 1
    start_a = 1; step(); start_a = 0;
    chk_a("t2_k0", 1, 16'h4AF5, 0, 1, 0);
    step(); chk_a("t2_k1", 1, 16'hDD28, 1, 1, 0);
    ready_a = 0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_a("t2_stall", 1, 16'hDD28, 1, 1, 0);
    end
    ready_a = 1;
    step(); chk_a("t2_k2", 1, 16'h87AF, 2, 1, 0);
    step(); chk_a("t2_done", 0, 16'h87AF, 2, 0, 1);

    // T3: start while busy is ignored
    start_a = 1; key_a = 16'h4AF5; step(); start_a = 0;
    chk_a("t3_k0", 1, 16'h4AF5, 0, 1, 0);
    step(); chk_a("t3_k1", 1, 16'hDD28, 1, 1, 0);
    start_a = 1; key_a = 16'h0000;
    step(); chk_a("t3_k2", 1, 16'h87AF, 2, 1, 0);
    start_a = 0;
    step(); chk_a("t3_done", 0, 16'h87AF, 2, 0, 1);

    // T4: reset mid-schedule, restart, and start accepted in done cycle
    key_a = 16'h4AF5; start_a = 1; step(); start_a = 0;
    step(); chk_a("t4_k1", 1, 16'hDD28, 1, 1, 0);
    rst = 1; step(); rst = 0;
    chk_a("t4_rst", 0, 16'h0000, 0, 0, 0);
    step(); chk_a("t4_idle", 0, 16'h0000, 0, 0, 0);
    start_a = 1; step(); start_a = 0;
    chk_a("t4_k0", 1, 16'h4AF5, 0, 1, 0);
    step(); chk_a("t4_k1b", 1, 16'hDD28, 1, 1, 0);
    step(); chk_a("t4_k2", 1, 16'h87AF, 2, 1, 0);
    step(); chk_a("t4_done", 0, 16'h87AF, 2, 0, 1);
    start_a = 1; step(); start_a = 0;
    chk_a("t4_rest_k0", 1, 16'h4AF5, 0, 1, 0);
    step(); step(); step();
    chk_a("t4_rest_done", 0, 16'h87AF, 2, 0, 1);

    // T5: 14 rounds from an all-zero key
    key_b = 16'h0000; start_b = 1; step(); start_b = 0;
    exp_k = 64'h0;
    for (int r = 0; r < 15; r++) begin
      chk("t5_valid", valid_b, 1);
      chk("t5_data", data_b, exp_k);
      chk("t5_idx", idx_b, r[3:0]);
      if (r == 1) chk("t5_key1", data_b, 16'h1919);
      if (r < 14) exp_k = model(exp_k, 2, rc_tab[r]);
      step();
    end
    chk("t5_done", done_b, 1);
    chk("t5_valid_end", valid_b, 0);
    chk("t5_idx_end", idx_b, 4'd14);

    // T6: 4-word keys with random back-pressure
    for (int s = 0; s < 2; s++) begin
      exp_k = {32'h0, $urandom()};
      key_c = exp_k[31:0]; start_c = 1; step(); start_c = 0;
      ntx = 0; cyc = 0;
      while (ntx < 6 && cyc < 200) begin
        ready_c = 1'($urandom_range(0, 1));
        chk("t6_valid", valid_c, 1);
        chk("t6_done_low", done_c, 0);
        if (valid_c) begin
          chk("t6_data", data_c, exp_k);
          chk("t6_idx", idx_c, ntx[3:0]);
          if (ready_c) begin
            if (ntx < 5) exp_k = model(exp_k, 4, rc_tab[ntx]);
            ntx++;
          end
        end
        step();
        cyc++;
      end
      ready_c = 0;
      chk("t6_ntx", ntx, 6);
      chk("t6_done", done_c, 1);
      chk("t6_valid_end", valid_c, 0);
      step();
      chk("t6_done_pulse", done_c, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
